// File: rtl/inverse_viewport_transform_if.sv
// Stream bundle for the inverse viewport transform: pixel input side with
// valid/ready, NDC vertex output side with valid/ready, and the sticky range flag.
interface inverse_viewport_transform_if;
  logic             valid_in;
  logic             ready_out;
  logic [8:0]       pixel_x_in;
  logic [7:0]       pixel_y_in;
  logic [1:0][31:0] depth_in;
  logic             valid_out;
  logic             ready_in;
  logic [3:0][31:0] vertex_out;
  logic             range_err_out;

  modport master (
    output valid_in, pixel_x_in, pixel_y_in, depth_in, ready_in,
    input  ready_out, valid_out, vertex_out, range_err_out
  );

  modport slave (
    input  valid_in, pixel_x_in, pixel_y_in, depth_in, ready_in,
    output ready_out, valid_out, vertex_out, range_err_out
  );
endinterface

// File: rtl/inverse_viewport_transform.sv
// Maps a screen pixel centre to fp32 NDC coordinates {w, z, y_ndc, x_ndc}.
// Input register, then S1 integer offsets, S2 int-to-fp32, S3 constant multiply with RNE.
module inverse_viewport_transform #(
  parameter int X_RES = 320,
  parameter int Y_RES = 240
) (
  input logic                         clk_in,
  input logic                         rst_in,
  inverse_viewport_transform_if.slave bus
);

  // 1/320 and 1/240 as fp32; only valid for the default resolution
  localparam logic [31:0] SCALE_X = 32'h3B4CCCCD;
  localparam logic [31:0] SCALE_Y = 32'h3B888889;

  logic                     advance;
  logic                     accept;

  logic                     in_valid;
  logic [8:0]               in_x;
  logic [7:0]               in_y;
  logic [1:0][31:0]         in_depth;

  logic signed [10:0]       nx_c;
  logic signed [10:0]       ny_c;
  logic                     in_range_c;

  logic                     s1_valid;
  logic signed [10:0]       s1_nx;
  logic signed [10:0]       s1_ny;
  logic [1:0][31:0]         s1_depth;

  logic [31:0]              fx_c;
  logic [31:0]              fy_c;

  logic                     s2_valid;
  logic [31:0]              s2_fx;
  logic [31:0]              s2_fy;
  logic [1:0][31:0]         s2_depth;

  logic [31:0]              x_ndc_c;
  logic [31:0]              y_ndc_c;

  logic                     s3_valid;
  logic [3:0][31:0]         vertex_q;
  logic                     range_err_q;

  // Exact conversion: every |n| fits in 24 bits, so the mantissa is just the
  // magnitude left-aligned with the leading one dropped.
  function automatic logic [31:0] int_to_fp(input logic signed [10:0] n);
    logic [9:0] mag;
    logic [3:0] lead;
    mag  = n[10] ? 10'(-n) : n[9:0];
    lead = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (mag[i]) lead = 4'(i);
    end
    return {n[10], 8'd127 + {4'd0, lead}, 23'({13'd0, mag} << (5'd23 - {1'b0, lead}))};
  endfunction

  // Normal operands only, so the product needs at most one normalising shift.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] k);
    logic [47:0] prod;
    logic [22:0] man;
    logic        guard;
    logic        sticky;
    logic [7:0]  e;
    logic [23:0] man_r;
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, k[22:0]};
    e    = a[30:23] + k[30:23] - 8'd127;
    if (prod[47]) begin
      man    = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      e      = e + 8'd1;
    end else begin
      man    = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    man_r = {1'b0, man} + {23'd0, guard & (sticky | man[0])};
    if (man_r[23]) e = e + 8'd1;
    return {a[31] ^ k[31], e, man_r[22:0]};
  endfunction

  // The whole pipeline moves together; only a full, unaccepted S3 stalls it.
  assign advance           = !s3_valid || bus.ready_in;
  assign accept            = bus.valid_in && advance;
  assign bus.ready_out     = advance;
  assign bus.valid_out     = s3_valid;
  assign bus.vertex_out    = vertex_q;
  assign bus.range_err_out = range_err_q;

  always_comb begin
    nx_c       = $signed({1'b0, in_x, 1'b1}) - $signed(11'(X_RES));
    ny_c       = $signed(11'(Y_RES)) - $signed({2'b0, in_y, 1'b1});
    in_range_c = (int'(in_x) < X_RES) && (int'(in_y) < Y_RES);
  end

  always_comb begin
    fx_c = int_to_fp(s1_nx);
    fy_c = int_to_fp(s1_ny);
  end

  always_comb begin
    x_ndc_c = fp_mul(s2_fx, SCALE_X);
    y_ndc_c = fp_mul(s2_fy, SCALE_Y);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      in_valid    <= 1'b0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s3_valid    <= 1'b0;
      range_err_q <= 1'b0;
      vertex_q    <= '0;
    end else begin
      // Out-of-range pixels die here, one edge after they were accepted
      if (in_valid && !in_range_c) range_err_q <= 1'b1;
      if (advance) begin
        in_valid <= accept;
        s1_valid <= in_valid && in_range_c;
        s2_valid <= s1_valid;
        s3_valid <= s2_valid;
        if (s2_valid) vertex_q <= {s2_depth, y_ndc_c, x_ndc_c};
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (advance) begin
      in_x     <= bus.pixel_x_in;
      in_y     <= bus.pixel_y_in;
      in_depth <= bus.depth_in;
      s1_nx    <= nx_c;
      s1_ny    <= ny_c;
      s1_depth <= in_depth;
      s2_fx    <= fx_c;
      s2_fy    <= fy_c;
      s2_depth <= s1_depth;
    end
  end

endmodule
